// File: rtl/pred_argmax_scanner.sv
// pred_argmax_scanner: iterative argmax over ENC signed BW-bit logits.
// The score vector is snapshotted on start, then one entry is compared per
// clock. The result (index, value, optional margin) is registered on the
// cycle that enters DONE.
// Optional feature: define PRED_ARGMAX_MARGIN_EN to build runner-up tracking
// and the saturated best-minus-runner-up margin output. Without it, margin is 0.
module pred_argmax_scanner #(
    parameter int ENC   = 27,
    parameter int BW    = 32,
    parameter int IDX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ENC*BW-1:0]  pred,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   char_idx,
    output logic [BW-1:0]      max_val,
    output logic [BW-1:0]      margin
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(ENC - 1);

    state_t                   state_r;
    // One spare slot on top keeps the shift window in range even for ENC==1.
    logic [(ENC+1)*BW-1:0]    snap_r;
    logic [BW-1:0]            best_r;
    logic [IDX_W-1:0]         best_idx_r;
    logic [IDX_W-1:0]         cnt_r;
    logic                     busy_r;
    logic                     done_r;
    logic [IDX_W-1:0]         char_idx_r;
    logic [BW-1:0]            max_val_r;

    logic [BW-1:0]            entry_s;
    logic                     gt_s;
    logic [BW-1:0]            nbest_s;
    logic [IDX_W-1:0]         nidx_s;

    // The entry under test is always in slot 1; the snapshot shifts down each SCAN cycle.
    assign entry_s = snap_r[BW +: BW];
    assign gt_s    = $signed(entry_s) > $signed(best_r);

`ifdef PRED_ARGMAX_MARGIN_EN
    localparam logic [BW-1:0] MOST_NEG   = {1'b1, {(BW-1){1'b0}}};
    localparam logic [BW-1:0] MARGIN_MAX = {1'b0, {(BW-1){1'b1}}};

    logic [BW-1:0] run_r;
    logic [BW-1:0] nrun_s;
    logic [BW-1:0] margin_r;

    // best - runner_up in BW+1 bits; result is never negative, so clamp any
    // value at or above 2^(BW-1) to the largest positive BW-bit number.
    function automatic logic [BW-1:0] sat_margin(input logic [BW-1:0] b,
                                                 input logic [BW-1:0] r);
        logic [BW:0] d;
        d = {b[BW-1], b} - {r[BW-1], r};
        if (d[BW] || d[BW-1]) begin
            sat_margin = MARGIN_MAX;
        end else begin
            sat_margin = d[BW-1:0];
        end
    endfunction

    // Runner-up update: displaced best on a new maximum, else the entry if it
    // beats the runner-up or ties the best (a tie gives zero margin).
    always_comb begin
        nrun_s = run_r;
        if (gt_s) begin
            nrun_s = best_r;
        end else if (($signed(entry_s) > $signed(run_r)) || (entry_s == best_r)) begin
            nrun_s = entry_s;
        end else begin
            nrun_s = run_r;
        end
    end

    assign margin = margin_r;
`else
    assign margin = {BW{1'b0}};
`endif

    // Best update: only a strictly greater entry takes over, so ties keep the lowest index.
    always_comb begin
        nbest_s = best_r;
        nidx_s  = best_idx_r;
        if (gt_s) begin
            nbest_s = entry_s;
            nidx_s  = cnt_r;
        end else begin
            nbest_s = best_r;
            nidx_s  = best_idx_r;
        end
    end

    // Control FSM, scan datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            snap_r     <= {((ENC+1)*BW){1'b0}};
            best_r     <= {BW{1'b0}};
            best_idx_r <= {IDX_W{1'b0}};
            cnt_r      <= {IDX_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            char_idx_r <= {IDX_W{1'b0}};
            max_val_r  <= {BW{1'b0}};
`ifdef PRED_ARGMAX_MARGIN_EN
            run_r      <= {BW{1'b0}};
            margin_r   <= {BW{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        snap_r     <= {{BW{1'b0}}, pred};
                        best_r     <= pred[BW-1:0];
                        best_idx_r <= {IDX_W{1'b0}};
                        cnt_r      <= IDX_W'(1);
                        busy_r     <= 1'b1;
`ifdef PRED_ARGMAX_MARGIN_EN
                        run_r      <= MOST_NEG;
`endif
                        if (ENC == 1) begin
                            // Single entry: the result is known at capture.
                            state_r    <= DONE;
                            done_r     <= 1'b1;
                            char_idx_r <= {IDX_W{1'b0}};
                            max_val_r  <= pred[BW-1:0];
`ifdef PRED_ARGMAX_MARGIN_EN
                            margin_r   <= MARGIN_MAX;
`endif
                        end else begin
                            state_r <= SCAN;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                SCAN: begin
                    best_r     <= nbest_s;
                    best_idx_r <= nidx_s;
                    snap_r     <= snap_r >> BW;
                    cnt_r      <= cnt_r + IDX_W'(1);
`ifdef PRED_ARGMAX_MARGIN_EN
                    run_r      <= nrun_s;
`endif
                    if (cnt_r == LAST_CNT) begin
                        state_r    <= DONE;
                        done_r     <= 1'b1;
                        char_idx_r <= nidx_s;
                        max_val_r  <= nbest_s;
`ifdef PRED_ARGMAX_MARGIN_EN
                        margin_r   <= sat_margin(nbest_s, nrun_s);
`endif
                    end else begin
                        state_r <= SCAN;
                    end
                end
                DONE: begin
                    // start is deliberately ignored here; it is not queued.
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign char_idx = char_idx_r;
    assign max_val  = max_val_r;

endmodule

// File: tb/tb_pred_argmax_scanner.sv
// Directed self-checking bench for pred_argmax_scanner at default parameters.
// Expected margin values depend on whether PRED_ARGMAX_MARGIN_EN is defined.
module tb_pred_argmax_scanner;

    localparam int ENC   = 27;
    localparam int BW    = 32;
    localparam int IDX_W = 6;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ENC*BW-1:0] pred;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  char_idx;
    logic [BW-1:0]     max_val;
    logic [BW-1:0]     margin;

    int checks;
    int errors;

    pred_argmax_scanner #(.ENC(ENC), .BW(BW), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pred     (pred),
        .busy     (busy),
        .done     (done),
        .char_idx (char_idx),
        .max_val  (max_val),
        .margin   (margin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and count it.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] exp_margin(input logic [BW-1:0] m);
`ifdef PRED_ARGMAX_MARGIN_EN
        return m;
`else
        return {BW{1'b0}};
`endif
    endfunction

    // Issue one scan of v; optionally scramble pred after capture. Watches 40 cycles.
    task automatic run_scan(input string tag, input logic [ENC*BW-1:0] v, input bit change_pred,
                            input logic [IDX_W-1:0] e_idx, input logic [BW-1:0] e_max,
                            input logic [BW-1:0] e_margin);
        int done_at;
        int ndone;
        pred  = v;
        start = 1'b1;
        step();
        start = 1'b0;
        if (change_pred) pred = {(ENC*BW){1'b0}};
        done_at = -1;
        ndone   = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            if (k == 1)       check_eq({tag, "_busy_first"}, 64'(busy), 64'd1);
            if (k == ENC)     check_eq({tag, "_busy_last"},  64'(busy), 64'd1);
            if (k == ENC + 1) check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
            if (k < 40) step();
        end
        check_eq({tag, "_done_cycle"}, 64'(done_at), 64'(ENC));
        check_eq({tag, "_done_count"}, 64'(ndone), 64'd1);
        check_eq({tag, "_idx"},    64'(char_idx), 64'(e_idx));
        check_eq({tag, "_max"},    64'(max_val),  64'(e_max));
        check_eq({tag, "_margin"}, 64'(margin),   64'(exp_margin(e_margin)));
    endtask

    initial begin : stim
        logic [ENC*BW-1:0] va;
        logic [ENC*BW-1:0] vb;
        int dq[$];
        bit seen_done;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        pred   = {(ENC*BW){1'b0}};
        step();
        step();
        rst = 1'b0;

        // Reset state and idle cycles.
        check_eq("rst_busy",   64'(busy),     64'd0);
        check_eq("rst_idx",    64'(char_idx), 64'd0);
        check_eq("rst_max",    64'(max_val),  64'd0);
        check_eq("rst_margin", 64'(margin),   64'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (done || busy) seen_done = 1'b1;
        end
        check_eq("idle_quiet", 64'(seen_done), 64'd0);
        check_eq("idle_done",  64'(done),      64'd0);

        // Single positive peak at entry 13.
        va = {(ENC*BW){1'b0}};
        va[13*BW +: BW] = 32'h0001_0000;
        run_scan("peak13", va, 1'b0, 6'd13, 32'h0001_0000, 32'h0001_0000);

        // All negative, maximum in the last slot; pred cleared right after capture.
        vb = {(ENC*BW){1'b0}};
        for (int i = 0; i < ENC; i++) vb[i*BW +: BW] = 32'hFFFF_FFFB;
        vb[26*BW +: BW] = 32'hFFFF_FFFF;
        run_scan("neg26", vb, 1'b1, 6'd26, 32'hFFFF_FFFF, 32'd4);

        // Tie at the top: lowest index wins, margin 0.
        vb = {(ENC*BW){1'b0}};
        vb[0*BW +: BW] = 32'h8000_0000;
        vb[4*BW +: BW] = 32'h7FFF_FFFF;
        vb[9*BW +: BW] = 32'h7FFF_FFFF;
        run_scan("tie", vb, 1'b0, 6'd4, 32'h7FFF_FFFF, 32'd0);

        // Widest spread: margin saturates.
        for (int i = 0; i < ENC; i++) vb[i*BW +: BW] = 32'h8000_0000;
        vb[0*BW +: BW] = 32'h7FFF_FFFF;
        run_scan("sat", vb, 1'b0, 6'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

        // start at 0, 5, 27 (ignored) and 28; second scan uses a new vector.
        vb = {(ENC*BW){1'b0}};
        vb[2*BW +: BW] = 32'd7;
        vb[20*BW +: BW] = 32'd9;
        dq.delete();
        for (int k = 0; k <= 60; k++) begin
            start = (k == 0 || k == 5 || k == 27 || k == 28);
            pred  = (k < 28) ? va : vb;
            if (done) dq.push_back(k);
            if (k == 27) check_eq("b2b_first_idx", 64'(char_idx), 64'd13);
            step();
        end
        start = 1'b0;
        check_eq("b2b_done_count", 64'(dq.size()), 64'd2);
        check_eq("b2b_done_first", 64'((dq.size() > 0) ? dq[0] : -1), 64'd27);
        check_eq("b2b_done_second", 64'((dq.size() > 1) ? dq[1] : -1), 64'd55);
        check_eq("b2b_second_idx", 64'(char_idx), 64'd20);
        check_eq("b2b_second_max", 64'(max_val),  64'd9);
        check_eq("b2b_second_margin", 64'(margin), 64'(exp_margin(32'd2)));

        // Reset mid-scan, then a fresh scan.
        pred = va;
        dq.delete();
        for (int k = 0; k <= 45; k++) begin
            start = (k == 0 || k == 12);
            rst   = (k == 10);
            if (done) dq.push_back(k);
            if (k == 11) begin
                check_eq("abort_busy", 64'(busy),     64'd0);
                check_eq("abort_idx",  64'(char_idx), 64'd0);
                check_eq("abort_max",  64'(max_val),  64'd0);
                check_eq("abort_margin", 64'(margin), 64'd0);
            end
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
        check_eq("abort_done_count", 64'(dq.size()), 64'd1);
        check_eq("abort_done_cycle", 64'((dq.size() > 0) ? dq[0] : -1), 64'd39);
        check_eq("abort_rescan_idx", 64'(char_idx), 64'd13);
        check_eq("abort_rescan_max", 64'(max_val),  64'h0001_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
